// File: rtl/multi_ported_sram_pkg.sv
// Shared definitions for the multi-ported SRAM front-end blocks.
//   init_state_t : init sequencer FSM states (IDLE/SWEEP/DRAIN)
//   ceil_div     : integer ceiling division used for sweep-length sizing
package multi_ported_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } init_state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/multi_ported_sram_wcollide.sv
// Same-cycle write collision filter: when enabled ports i<j target the same
// address, port i is dropped so the highest-index writer wins.
// Ports:
//   wen   in  NUM_W     raw write enables
//   waddr in  NUM_W*AW  write addresses
//   wen_c out NUM_W     filtered write enables (combinational)
module multi_ported_sram_wcollide
  import multi_ported_sram_pkg::*;
#(
  parameter int unsigned NUM_W = 1,
  parameter int unsigned AW    = 3
) (
  input  logic [NUM_W-1:0]    wen,
  input  logic [NUM_W*AW-1:0] waddr,
  output logic [NUM_W-1:0]    wen_c
);

  // Priority filter: any enabled higher-index port on the same address kills port i.
  always_comb begin
    wen_c = wen;
    for (int i = 0; i < NUM_W; i++) begin
      for (int j = i + 1; j < NUM_W; j++) begin
        if (wen[i] && wen[j] && (waddr[i*AW +: AW] == waddr[j*AW +: AW])) begin
          wen_c[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multi_ported_sram_init_seq.sv
// Init sequencer in front of the XOR-based multi-ported SRAM. Sweeps every
// address with INIT_VALUE (all write ports in parallel) after reset or an
// init pulse, otherwise forwards client requests through one register stage.
// Optional feature macro: MULTI_PORTED_SRAM_INIT_COLLISION_EN enables the
// same-address write filter on forwarded client writes.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   init                          sweep request pulse (ignored while busy)
//   c_wen/c_waddr/c_wdata         client write request
//   c_ren/c_raddr                 client read request
//   wen/waddr/wdata/ren/raddr     registered SRAM request bus
//   busy_w                        sweep in progress, client must not issue
//   init_done                     one-cycle pulse in the final (drain) cycle
//   drop_err                      sticky: request seen while busy
module multi_ported_sram_init_seq
  import multi_ported_sram_pkg::*;
#(
  parameter int unsigned NUM_W         = 1,
  parameter int unsigned NUM_R         = 1,
  parameter int unsigned W             = 32,
  parameter int unsigned N             = 8,
  parameter logic [W-1:0] INIT_VALUE   = '0,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init,
  input  logic [NUM_W-1:0]            c_wen,
  input  logic [NUM_W*$clog2(N)-1:0]  c_waddr,
  input  logic [NUM_W*W-1:0]          c_wdata,
  input  logic [NUM_R-1:0]            c_ren,
  input  logic [NUM_R*$clog2(N)-1:0]  c_raddr,
  output logic [NUM_W-1:0]            wen,
  output logic [NUM_W*$clog2(N)-1:0]  waddr,
  output logic [NUM_W*W-1:0]          wdata,
  output logic [NUM_R-1:0]            ren,
  output logic [NUM_R*$clog2(N)-1:0]  raddr,
  output logic                        busy_w,
  output logic                        init_done,
  output logic                        drop_err
);

  localparam int unsigned AW        = $clog2(N);
  localparam int unsigned SWEEP_LEN = ceil_div(N, NUM_W);
  localparam int unsigned KW        = $clog2(SWEEP_LEN) + 1;
  // Wide enough that k*NUM_W+p never wraps before the < N compare.
  localparam int unsigned EW        = AW + $clog2(NUM_W) + 1;

  typedef logic [AW-1:0] addr_t;
  typedef logic [W-1:0]  word_t;

  init_state_t             state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    start_pend_q, start_pend_d;
  logic [NUM_W-1:0]        wen_d;
  logic [NUM_W*AW-1:0]     waddr_d;
  logic [NUM_W*W-1:0]      wdata_d;
  logic [NUM_R-1:0]        ren_d;
  logic [NUM_R*AW-1:0]     raddr_d;
  logic                    busy_d, done_d, derr_d;
  logic [EW-1:0]           sweep_addr;
  logic [NUM_W-1:0]        c_wen_f;

`ifdef MULTI_PORTED_SRAM_INIT_COLLISION_EN
  multi_ported_sram_wcollide #(
    .NUM_W (NUM_W),
    .AW    (AW)
  ) u_wcollide (
    .wen   (c_wen),
    .waddr (c_waddr),
    .wen_c (c_wen_f)
  );
`else
  assign c_wen_f = c_wen;
`endif

  // State and registered output bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      start_pend_q <= INIT_ON_RESET;
      wen          <= '0;
      waddr        <= '0;
      wdata        <= '0;
      ren          <= '0;
      raddr        <= '0;
      busy_w       <= 1'b0;
      init_done    <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      start_pend_q <= start_pend_d;
      wen          <= wen_d;
      waddr        <= waddr_d;
      wdata        <= wdata_d;
      ren          <= ren_d;
      raddr        <= raddr_d;
      busy_w       <= busy_d;
      init_done    <= done_d;
      drop_err     <= derr_d;
    end
  end

  // Next state and next bus contents.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    start_pend_d = start_pend_q;
    wen_d        = '0;
    waddr_d      = '0;
    wdata_d      = '0;
    ren_d        = '0;
    raddr_d      = '0;
    derr_d       = drop_err;
    sweep_addr   = '0;

    case (state_q)
      IDLE: begin
        wen_d   = c_wen_f;
        waddr_d = c_waddr;
        wdata_d = c_wdata;
        ren_d   = c_ren;
        raddr_d = c_raddr;
        // start_pend carries the reset-triggered sweep into the first live cycle
        if (init || start_pend_q) begin
          state_d      = SWEEP;
          k_d          = '0;
          start_pend_d = 1'b0;
          derr_d       = 1'b0;
        end
      end
      SWEEP: begin
        for (int p = 0; p < NUM_W; p++) begin
          sweep_addr                = EW'(k_q) * EW'(NUM_W) + EW'(p);
          wen_d[p]                  = (sweep_addr < EW'(N));
          waddr_d[p*AW +: AW]       = addr_t'(sweep_addr);
          wdata_d[p*W +: W]         = word_t'(INIT_VALUE);
        end
        if (k_q == KW'(SWEEP_LEN - 1)) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests while busy are discarded and flagged.
    if ((state_q != IDLE) && ((|c_wen) || (|c_ren))) begin
      derr_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DRAIN);
  end

endmodule
